// File: rtl/io_read_sequencer_pkg.sv
// Shared state encoding and helpers for the switch-read sequencer.
package io_read_sequencer_pkg;

  localparam int IO_WIDTH = 16;

  typedef enum logic [1:0] {
    IOS_IDLE         = 2'd0,
    IOS_WAIT_PRESS   = 2'd1,
    IOS_WAIT_RELEASE = 2'd2,
    IOS_DONE         = 2'd3
  } ios_state_e;

  // Fetch is held from the moment a read is requested until the DONE cycle.
  function automatic logic ios_stalls(ios_state_e s, logic req);
    return ((s == IOS_IDLE) && req) || (s == IOS_WAIT_PRESS) || (s == IOS_WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/io_read_sequencer_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-level debounce counter and
// one-cycle press/release pulses on accepted level changes.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press_evt,
  output logic release_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Any sample agreeing with the stable level restarts the count, so only an
  // unbroken run of disagreeing samples flips the level.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      level       <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt         <= '0;
        level       <= ~level;
        press_evt   <= ~level;
        release_evt <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_read_sequencer.sv
// Switch-read sequencer: stalls fetch on an IO switch read until confirm_button is
// pressed and released. Macro IO_TIMEOUT_EN adds a press-wait timeout (zero data).
module io_read_sequencer
  import io_read_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int SW_W            = IO_WIDTH
`ifdef IO_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1000000
`endif
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            io_read_req,
  input  logic            confirm_button,
  input  logic [SW_W-1:0] switches,
  output logic            stall,
  output logic [SW_W-1:0] sw_data,
  output logic            data_valid,
  output logic            busy,
  output logic            timeout
);

  ios_state_e state;
  ios_state_e state_next;
  logic       press_evt;
  logic       release_evt;
  logic       unused_level;
  logic       to_hit;

  // The pulses carry everything the sequencer needs; the level itself is not used.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clock      (clock),
    .rst        (rst),
    .btn_in     (confirm_button),
    .level      (unused_level),
    .press_evt  (press_evt),
    .release_evt(release_evt)
  );

`ifdef IO_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;

  assign to_hit = (state == IOS_WAIT_PRESS) && (to_cnt == TO_LAST);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != IOS_WAIT_PRESS) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // A real press in the final cycle still wins over the timeout.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else if ((state == IOS_IDLE) && io_read_req) begin
      timeout <= 1'b0;
    end else if (to_hit && !press_evt) begin
      timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= IOS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE always returns to IDLE, so a request still high there cannot re-trigger.
  always_comb begin
    state_next = state;
    stall      = rst & ios_stalls(state, io_read_req);
    data_valid = (state == IOS_DONE);
    busy       = (state != IOS_IDLE);
    unique case (state)
      IOS_IDLE: begin
        if (io_read_req) state_next = IOS_WAIT_PRESS;
      end
      IOS_WAIT_PRESS: begin
        if (press_evt)   state_next = IOS_WAIT_RELEASE;
        else if (to_hit) state_next = IOS_DONE;
      end
      IOS_WAIT_RELEASE: begin
        if (release_evt) state_next = IOS_DONE;
      end
      IOS_DONE: begin
        state_next = IOS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sw_data <= '0;
    end else if (state == IOS_WAIT_PRESS) begin
      if (press_evt)   sw_data <= switches;
      else if (to_hit) sw_data <= '0;
    end
  end

endmodule

// File: doc/io_read_sequencer.md
Name: io_read_sequencer

Overview:
- Sequences the minisys datapath for switch-input reads.
- When the decoded instruction is an IO read from the switch device, the block stalls instruction fetch until the operator presses and releases confirm_button.
- It latches the switch value at the debounced press and releases the CPU for exactly one cycle, during which the instruction completes with the latched data.
- Sits between the board pins (switches, confirm_button) and IFetch/ioread on clk1.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (about 20 ms at clk1).
- CNT_W, 20, width of debounce and timeout counters; must hold DEBOUNCE_CYCLES and TIMEOUT_CYCLES.
- SW_W, 16, switch/data width; equals `IO_WIDTH.
- TIMEOUT_CYCLES, 1000000, press-wait limit; used only with IO_TIMEOUT_EN.

Ports:
- clock  input  1  CPU clock (clk1); all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- io_read_req  input  1  IORead & SwitchCtrl for the current instruction.
- confirm_button  input  1  raw, asynchronous button level; 1 = pressed.
- switches  input  SW_W  raw switch levels.
- stall  output  1  to IFetch: hold PC and suppress register/memory writes.
- sw_data  output  SW_W  latched switch value to ioread.
- data_valid  output  1  one-cycle pulse; instruction may complete this cycle.
- busy  output  1  FSM not in IDLE.
- timeout  output  1  last read ended by timeout; tied 0 without IO_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; stall=0, data_valid=0, busy=0, timeout=0, sw_data=0.
  - Synchronizer flops and debounced level cleared to 0; counters cleared.
  - Reset asserted mid-operation aborts the read with no data_valid pulse.
- Button conditioning:
  - 2-flop synchronizer, then debounce.
  - Counter increments while synced level != stable level; clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level toggles and the counter clears.
  - press_evt / release_evt are one-cycle pulses on stable 0->1 / 1->0.
  - Latency from raw edge to event: DEBOUNCE_CYCLES+2 cycles.
- FSM states and transitions:
  - IDLE: io_read_req=1 -> WAIT_PRESS.
  - WAIT_PRESS: press_evt -> WAIT_RELEASE; sw_data <= switches (registered on that edge).
  - WAIT_RELEASE: release_evt -> DONE.
  - DONE: unconditionally -> IDLE the next cycle.
- stall:
  - Combinational: (IDLE & io_read_req) | WAIT_PRESS | WAIT_RELEASE.
  - Asserts in the same cycle the request appears.
  - Deasserted in DONE.
- data_valid:
  - 1 only in DONE.
  - The CPU writes sw_data to rt on that edge, and the PC advances.
- DONE ignores io_read_req, which is still high for the same instruction, so there is no re-trigger. Back-to-back IO reads each require their own press/release.
- Button already stably pressed when the request arrives: no press_evt is generated. The operator must release and press again.
- Switch changes after press_evt do not affect sw_data. sw_data holds until the next press_evt or reset.
- Bounces shorter than DEBOUNCE_CYCLES produce no events.
- io_read_req=0 in IDLE: stall=0; the block is transparent.

Optional Feature:
- Macro IO_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in WAIT_PRESS and clears on entry.
  - Reaching TIMEOUT_CYCLES-1 -> DONE, with sw_data <= 0 and timeout <= 1.
  - timeout clears on the next entry to WAIT_PRESS.
  - WAIT_RELEASE has no timeout.
- Undefined: no timeout counter; WAIT_PRESS waits indefinitely; timeout output is constant 0.

Decomposition:
- definitions.v additions:
  - State encodings IOS_IDLE=2'd0, IOS_WAIT_PRESS=2'd1, IOS_WAIT_RELEASE=2'd2, IOS_DONE=2'd3.
  - Reuse `IO_WIDTH for SW_W.
- Sub-module btn_debounce (synchronizer + debounce counter + edge pulses):
  - Parameters DEBOUNCE_CYCLES, CNT_W.
  - Ports clock, rst, btn_in, level, press_evt, release_evt.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset: hold rst=0 with button high and io_read_req=1 -> stall=0, busy=0, sw_data=0, no data_valid.
- Clean read:
  - io_read_req=1, switches=16'hA5C3, button 0->1 for 10 cycles then 0 -> stall high from first cycle.
  - sw_data=16'hA5C3 at press_evt+1.
  - One data_valid pulse 1 cycle after release_evt, stall low in that cycle, then IDLE.
- Bounce: toggle button every 2 cycles for 12 cycles, then steady high -> no event during bouncing; press_evt exactly 6 cycles after last transition.
- Held button plus switch change:
  - Button stable high before request -> stays in WAIT_PRESS until release and re-press.
  - switches change 16'h0001->16'h0002 after press_evt -> sw_data stays 16'h0001.
- Back-to-back: io_read_req high for two consecutive instructions -> two distinct press/release cycles, two data_valid pulses, no re-trigger in DONE.
- IO_TIMEOUT_EN, TIMEOUT_CYCLES=20: no press after request -> DONE after 20 cycles in WAIT_PRESS, with sw_data=0, timeout=1, data_valid=1; rst=0 mid-WAIT_RELEASE -> IDLE immediately.
